// File: rtl/regfile_port_arbiter_pkg.sv
// Shared types and constants for the register-file port arbiter.
// Holds the memory geometry, the grant-select enum and the word-to-byte address helper.
package regfile_arb_pkg;

    localparam int MEM_BYTES = 512;
    localparam int MEM_AW    = 9;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 30;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RD0,
        GNT_RD1,
        GNT_WR
    } gnt_e;

    // Only the low word-address bits survive; upper bits alias onto the 128 reachable words.
    function automatic logic [MEM_AW-1:0] byte_addr(input logic [ADDR_W-1:0] word_addr);
        return {word_addr[MEM_AW-3:0], 2'b00};
    endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Bundle of requester, response and memory-port signals around the arbiter.
// slave = arbiter side, master = requesters plus the memory model.
interface regfile_arb_if;
    import regfile_arb_pkg::*;

    logic              rd0_valid;
    logic [ADDR_W-1:0] rd0_addr;
    logic              rd0_ready;
    logic              rd0_rsp_valid;
    logic [DATA_W-1:0] rd0_rsp_data;

    logic              rd1_valid;
    logic [ADDR_W-1:0] rd1_addr;
    logic              rd1_ready;
    logic              rd1_rsp_valid;
    logic [DATA_W-1:0] rd1_rsp_data;

    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;

    logic [MEM_AW-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  rd0_valid, rd0_addr, rd1_valid, rd1_addr,
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output rd0_ready, rd0_rsp_valid, rd0_rsp_data,
        output rd1_ready, rd1_rsp_valid, rd1_rsp_data,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output rd0_valid, rd0_addr, rd1_valid, rd1_addr,
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  rd0_ready, rd0_rsp_valid, rd0_rsp_data,
        input  rd1_ready, rd1_rsp_valid, rd1_rsp_data,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/regfile_port_arbiter_pick.sv
// Combinational grant selection: writes first unless the streak limit is hit
// while a read waits; ties between the two reads go to the channel not served last.
module regfile_arb_pick
    import regfile_arb_pkg::*;
#(
    parameter int WR_STREAK_MAX = 4
) (
    input  logic [1:0] rd_valid_i,
    input  logic       wr_valid_i,
    input  logic [2:0] streak_i,
    input  logic       rr_last_i,
    output gnt_e       gnt_o
);

    localparam logic [2:0] STREAK_MAX = 3'(WR_STREAK_MAX);

    always_comb begin
        gnt_o = GNT_NONE;
        if (wr_valid_i && ((rd_valid_i == 2'b00) || (streak_i < STREAK_MAX))) begin
            gnt_o = GNT_WR;
        end else if (rd_valid_i == 2'b11) begin
            gnt_o = rr_last_i ? GNT_RD0 : GNT_RD1;
        end else if (rd_valid_i[0]) begin
            gnt_o = GNT_RD0;
        end else if (rd_valid_i[1]) begin
            gnt_o = GNT_RD1;
        end
    end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one memory port between two readers and one writer with a write-streak limit.
// Define REGFILE_ARB_SVA_EN to compile in the concurrent properties.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int WR_STREAK_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    regfile_arb_if.slave bus
);

    logic [1:0]        rd_valid;
    logic [ADDR_W-1:0] rd_addr [2];
    logic [1:0]        rd_gnt;
    gnt_e              gnt_pick;
    gnt_e              gnt;

    logic [2:0]        streak_q, streak_d;
    logic              rr_last_q, rr_last_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q [2];

    assign rd_valid   = {bus.rd1_valid, bus.rd0_valid};
    assign rd_addr[0] = bus.rd0_addr;
    assign rd_addr[1] = bus.rd1_addr;

    regfile_arb_pick #(
        .WR_STREAK_MAX (WR_STREAK_MAX)
    ) u_pick (
        .rd_valid_i (rd_valid),
        .wr_valid_i (bus.wr_valid),
        .streak_i   (streak_q),
        .rr_last_i  (rr_last_q),
        .gnt_o      (gnt_pick)
    );

    // Grants are suppressed while reset is high so nothing transfers in that cycle.
    assign gnt       = rst ? GNT_NONE : gnt_pick;
    assign rd_gnt[0] = (gnt == GNT_RD0);
    assign rd_gnt[1] = (gnt == GNT_RD1);

    assign bus.rd0_ready = rd_gnt[0];
    assign bus.rd1_ready = rd_gnt[1];
    assign bus.wr_ready  = (gnt == GNT_WR);
    assign bus.mem_we    = bus.wr_ready;
    assign bus.mem_wdata = bus.wr_data;
    assign bus.mem_addr  = mem_addr_d;

    always_comb begin
        mem_addr_d = mem_addr_q;
        rr_last_d  = rr_last_q;
        streak_d   = '0;
        case (gnt)
            GNT_WR:  mem_addr_d = byte_addr(bus.wr_addr);
            GNT_RD0: begin
                mem_addr_d = byte_addr(rd_addr[0]);
                rr_last_d  = 1'b0;
            end
            GNT_RD1: begin
                mem_addr_d = byte_addr(rd_addr[1]);
                rr_last_d  = 1'b1;
            end
            default: ;
        endcase
        if ((gnt == GNT_WR) && (rd_valid != 2'b00)) begin
            streak_d = streak_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q    <= '0;
            rr_last_q   <= 1'b1;
            mem_addr_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            streak_q    <= streak_d;
            rr_last_q   <= rr_last_d;
            mem_addr_q  <= mem_addr_d;
            rsp_valid_q <= rd_gnt;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rsp_data_q[gi] <= '0;
            end else if (rd_gnt[gi]) begin
                rsp_data_q[gi] <= bus.mem_rdata;
            end
        end
    end

    assign bus.rd0_rsp_valid = rsp_valid_q[0];
    assign bus.rd1_rsp_valid = rsp_valid_q[1];
    assign bus.rd0_rsp_data  = rsp_data_q[0];
    assign bus.rd1_rsp_data  = rsp_data_q[1];

`ifdef REGFILE_ARB_SVA_EN
    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        $onehot0({bus.rd0_ready, bus.rd1_ready, bus.wr_ready}));

    a_we_is_wr: assert property (@(posedge clk) disable iff (rst)
        bus.mem_we |-> bus.wr_ready);

    a_rd0_progress: assert property (@(posedge clk) disable iff (rst)
        bus.rd0_valid |-> ##[0:WR_STREAK_MAX+2] (bus.rd0_ready || !bus.rd0_valid));

    a_rd1_progress: assert property (@(posedge clk) disable iff (rst)
        bus.rd1_valid |-> ##[0:WR_STREAK_MAX+2] (bus.rd1_ready || !bus.rd1_valid));

    // Back-to-back grants to the same word must observe the same stored byte.
    a_coherent_01: assert property (@(posedge clk) disable iff (rst)
        (bus.rd0_ready ##1 (bus.rd1_ready && (byte_addr(bus.rd1_addr) == $past(byte_addr(bus.rd0_addr)))))
        |=> (bus.rd1_rsp_data == bus.rd0_rsp_data));

    a_coherent_10: assert property (@(posedge clk) disable iff (rst)
        (bus.rd1_ready ##1 (bus.rd0_ready && (byte_addr(bus.rd0_addr) == $past(byte_addr(bus.rd1_addr)))))
        |=> (bus.rd0_rsp_data == bus.rd1_rsp_data));
`endif

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 512-byte memory on the port.
module tb_regfile_port_arbiter;
    import regfile_arb_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    regfile_arb_if bus ();

    regfile_port_arbiter #(
        .WR_STREAK_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] mem [MEM_BYTES];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [8:0] exp_baddr);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        #1;
        chk("wr_grant", {31'd0, bus.wr_ready}, 32'd1);
        chk("wr_mem_addr", {23'd0, bus.mem_addr}, {23'd0, exp_baddr});
        tick();
        $display("write addr=%0h data=%0h", a, d);
        bus.wr_valid = 1'b0;
    endtask

    logic [10:0] exp_wr_seq;

    initial begin
        checks = 0;
        errors = 0;
        exp_wr_seq = 11'b10111101111;

        rst = 1'b1;
        bus.rd0_valid = 1'b1;
        bus.rd1_valid = 1'b1;
        bus.wr_valid  = 1'b1;
        bus.rd0_addr  = '0;
        bus.rd1_addr  = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = 8'h5A;
        #2;
        chk("reset_grants", {28'd0, bus.rd0_ready, bus.rd1_ready, bus.wr_ready, bus.mem_we}, 32'd0);
        chk("reset_mem_addr", {23'd0, bus.mem_addr}, 32'd0);
        chk("reset_rsp_valid", {30'd0, bus.rd0_rsp_valid, bus.rd1_rsp_valid}, 32'd0);
        chk("reset_rsp_data", {16'd0, bus.rd0_rsp_data, bus.rd1_rsp_data}, 32'd0);
        chk("reset_wdata_follows", {24'd0, bus.mem_wdata}, 32'h5A);
        $display("reset state checked");
        tick();
        tick();
        rst = 1'b0;
        bus.rd0_valid = 1'b0;
        bus.rd1_valid = 1'b0;
        bus.wr_valid  = 1'b0;

        do_write(30'd5, 8'hA5, 9'd20);
        do_write(30'd0, 8'h11, 9'd0);
        do_write(30'd1, 8'h21, 9'd4);
        do_write(30'd2, 8'h42, 9'd8);

        // Both readers held: rd0 first, then alternate.
        bus.rd0_valid = 1'b1; bus.rd0_addr = 30'd1;
        bus.rd1_valid = 1'b1; bus.rd1_addr = 30'd2;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready", {30'd0, bus.rd0_ready, bus.rd1_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("rr_mem_addr", {23'd0, bus.mem_addr}, (i % 2 == 0) ? 32'd4 : 32'd8);
            tick();
            chk("rr_rsp_valid", {30'd0, bus.rd0_rsp_valid, bus.rd1_rsp_valid}, (i % 2 == 0) ? 32'd2 : 32'd1);
            chk("rr_rsp_data", {24'd0, (i % 2 == 0) ? bus.rd0_rsp_data : bus.rd1_rsp_data},
                (i % 2 == 0) ? 32'h21 : 32'h42);
            $display("rr step %0d rsp0=%0h rsp1=%0h", i, bus.rd0_rsp_data, bus.rd1_rsp_data);
        end
        bus.rd0_valid = 1'b0;
        bus.rd1_valid = 1'b0;

        // Single-cycle read of word 5.
        bus.rd0_valid = 1'b1; bus.rd0_addr = 30'd5;
        #1;
        chk("single_ready", {31'd0, bus.rd0_ready}, 32'd1);
        tick();
        bus.rd0_valid = 1'b0;
        chk("single_rsp_valid", {31'd0, bus.rd0_rsp_valid}, 32'd1);
        chk("single_rsp_data", {24'd0, bus.rd0_rsp_data}, 32'hA5);
        tick();
        chk("single_pulse_end", {31'd0, bus.rd0_rsp_valid}, 32'd0);
        chk("single_data_hold", {24'd0, bus.rd0_rsp_data}, 32'hA5);
        $display("single read rsp=%0h", bus.rd0_rsp_data);

        // Write streak limiter against a held rd1.
        bus.wr_valid = 1'b1; bus.wr_addr = 30'd10; bus.wr_data = 8'h77;
        bus.rd1_valid = 1'b1; bus.rd1_addr = 30'd5;
        for (int i = 0; i < 11; i++) begin
            #1;
            chk("streak_grant", {30'd0, bus.wr_ready, bus.rd1_ready}, exp_wr_seq[i] ? 32'd2 : 32'd1);
            tick();
            $display("streak cycle %0d wr=%0b rd1_rsp=%0b", i, exp_wr_seq[i], bus.rd1_rsp_valid);
        end
        bus.wr_valid = 1'b0;
        bus.rd1_valid = 1'b0;
        chk("streak_rd1_data", {24'd0, bus.rd1_rsp_data}, 32'hA5);

        // Write followed immediately by a read of the same word.
        do_write(30'd7, 8'h3C, 9'd28);
        bus.rd0_valid = 1'b1; bus.rd0_addr = 30'd7;
        #1;
        chk("raw_ready", {31'd0, bus.rd0_ready}, 32'd1);
        tick();
        bus.rd0_valid = 1'b0;
        chk("raw_rsp", {23'd0, bus.rd0_rsp_valid, bus.rd0_rsp_data}, 32'h13C);
        $display("write-then-read rsp=%0h", bus.rd0_rsp_data);

        // Address aliasing through the ignored upper bits.
        bus.rd0_valid = 1'b1; bus.rd0_addr = 30'h80;
        #1;
        chk("alias0_mem_addr", {23'd0, bus.mem_addr}, 32'd0);
        tick();
        bus.rd0_valid = 1'b0;
        chk("alias0_rsp", {23'd0, bus.rd0_rsp_valid, bus.rd0_rsp_data}, 32'h111);
        bus.rd1_valid = 1'b1; bus.rd1_addr = 30'h3FFF_FF85;
        #1;
        chk("alias1_mem_addr", {23'd0, bus.mem_addr}, 32'd20);
        tick();
        bus.rd1_valid = 1'b0;
        chk("alias1_rsp", {23'd0, bus.rd1_rsp_valid, bus.rd1_rsp_data}, 32'h1A5);
        $display("alias reads rsp0=%0h rsp1=%0h", bus.rd0_rsp_data, bus.rd1_rsp_data);

        // Reset asserted during a grant cycle with a response pulse in flight.
        bus.rd1_valid = 1'b1; bus.rd1_addr = 30'd1;
        tick();
        chk("mid_pre_rsp1", {31'd0, bus.rd1_rsp_valid}, 32'd1);
        bus.rd1_valid = 1'b0;
        bus.rd0_valid = 1'b1; bus.rd0_addr = 30'd2;
        #1;
        chk("mid_pre_ready0", {31'd0, bus.rd0_ready}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_grants", {28'd0, bus.rd0_ready, bus.rd1_ready, bus.wr_ready, bus.mem_we}, 32'd0);
        chk("mid_rsp_valid", {30'd0, bus.rd0_rsp_valid, bus.rd1_rsp_valid}, 32'd0);
        chk("mid_mem_addr", {23'd0, bus.mem_addr}, 32'd0);
        chk("mid_rsp_data", {16'd0, bus.rd0_rsp_data, bus.rd1_rsp_data}, 32'd0);
        tick();
        chk("mid_no_rsp", {30'd0, bus.rd0_rsp_valid, bus.rd1_rsp_valid}, 32'd0);
        $display("reset during grant checked");
        rst = 1'b0;

        // Fresh tie after reset goes to rd0.
        bus.rd1_valid = 1'b1; bus.rd1_addr = 30'd1;
        #1;
        chk("post_tie", {30'd0, bus.rd0_ready, bus.rd1_ready}, 32'd2);
        tick();
        bus.rd0_valid = 1'b0;
        bus.rd1_valid = 1'b0;
        chk("post_tie_rsp", {23'd0, bus.rd0_rsp_valid, bus.rd0_rsp_data}, 32'h142);
        $display("post-reset tie rsp0=%0h", bus.rd0_rsp_data);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Arbiter and sequencer for the single-port 512-byte register-file memory used in the RISC-V ILA lemma-check harnesses. It shares the memory's one access port between two word-addressed read requesters and one write requester. Writes have fixed priority, reads are served round-robin, and a write-streak limiter guarantees read progress. Read data returns one cycle after grant, so the lemma properties can compare the two read channels against a single coherent store.

## Interface
- WR_STREAK_MAX, 4: maximum consecutive write grants while any read is pending; legal range 1..7.
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- rd0_valid / rd1_valid  in  1  read request from channel 0 / 1
- rd0_addr / rd1_addr  in  30  word address
- rd0_ready / rd1_ready  out  1  grant for channel 0 / 1 this cycle
- rd0_rsp_valid / rd1_rsp_valid  out  1  one-cycle pulse; response data valid
- rd0_rsp_data / rd1_rsp_data  out  8  registered read byte
- wr_valid  in  1  write request
- wr_addr  in  30  word address
- wr_data  in  8  write byte
- wr_ready  out  1  write grant this cycle
- mem_addr  out  9  memory byte address
- mem_we  out  1  memory write enable; memory writes at the rising edge
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  combinational memory read data for mem_addr

## Operation
- Byte address is {addr, 2'b00}[8:0]. Only 128 words are reachable. Address bits [29:7] are ignored, so word addresses that differ only in those bits alias the same byte.
- At most one grant per cycle. Each grant is combinational from the current valids and state. A transfer completes when valid and ready are both high.
- Priority, evaluated each cycle:
  1. If wr_valid and (no read valid, or streak < WR_STREAK_MAX), grant the write.
  2. Otherwise grant a read. If both reads are valid, grant the channel that was not granted last (rr_last). If only one read is valid, grant it.
- Streak counter, 3 bits:
  - Increments on a write grant while any read is valid.
  - Clears on any read grant, and on any cycle with no read valid.
  - When streak == WR_STREAK_MAX and a read is valid, the read wins and the streak clears.
- rr_last updates on every read grant to the granted channel.
- mem_addr is driven as follows:
  - On a write grant: the write address.
  - On a read grant: the granted read address.
  - Otherwise: the last driven value, held from a register so there is no glitching toggle.
- mem_we = wr_ready. mem_wdata = wr_data.
- Read response: on a read grant, mem_rdata is captured into rdN_rsp_data and rdN_rsp_valid pulses for exactly one cycle. There is no response backpressure.
- rdN_rsp_data holds its value until the next response on the same channel.
- Requesters must not make valid depend on ready. Ready may depend on all valids combinationally.

## Timing
- Reset values:
  - All ready outputs 0 while reset is high.
  - rd0_rsp_valid = rd1_rsp_valid = 0; rd0_rsp_data = rd1_rsp_data = 8'h00.
  - mem_we = 0; mem_addr = 9'h000; mem_wdata follows wr_data.
  - streak = 0; rr_last = channel 1, so channel 0 wins the first tie.
- Read latency: grant at cycle N, response pulse at N+1.
- Write takes effect at the edge ending cycle N. A read granted at N+1 to the same address returns the new byte at N+2.
- A read and a write can never be granted in the same cycle, so there is no read-during-write hazard.
- Reset asserted mid-operation: a grant in that cycle is dropped, no response is produced, and the pending rsp_valid pulse is cleared asynchronously.

## Configuration
- REGFILE_ARB_SVA_EN defined: compiles in concurrent properties.
  - Assert: at most one ready per cycle.
  - Assert: mem_we implies wr_ready.
  - Assert: a held read valid is granted within WR_STREAK_MAX+2 cycles.
  - Coherence lemma: assume the two reads target the same address in consecutive grant cycles with no write grant between them; assert the two responses carry equal data.
- Undefined: no properties are compiled. Logic is identical in both cases.

## Structure
- Shared package regfile_arb_pkg:
  - MEM_BYTES = 512, MEM_AW = 9, DATA_W = 8, ADDR_W = 30.
  - Grant-select enum: GNT_NONE, GNT_RD0, GNT_RD1, GNT_WR.
  - Byte-address conversion function.
- One sub-module, regfile_arb_pick: combinational priority/round-robin pick from the valids, streak and rr_last.
- Top level holds streak, rr_last, mem_addr hold and response registers.

## Test plan
- Reset, then rd0_addr = 5 with rd0_valid high for one cycle; memory byte 20 = 8'hA5 -> rd0_ready at N, rd0_rsp_valid with 8'hA5 at N+1.
- rd0 and rd1 valid continuously at addresses 1 and 2 -> grants alternate rd0, rd1, rd0, ...; the first grant after reset goes to rd0.
- wr_valid and rd1_valid held, WR_STREAK_MAX = 4 -> four write grants, then one rd1 grant, then writes resume.
- Write 8'h3C to address 7 at cycle N, read address 7 at N+1 -> response 8'h3C at N+2.
- rd0_addr = 30'h80 with byte 0 = 8'h11 -> returns 8'h11, confirming aliasing to address 0.
- Assert reset in the cycle rd0 is granted -> no rsp_valid pulse, all outputs at reset values in that cycle.
